// File: rtl/iommu_pdtc.sv
// Fully associative process-directory-table cache keyed by (device_id, process_id).
// Registered one-cycle lookup, tree-PLRU replacement, three-mode flush, saturating counters.
module iommu_pdtc #(
  parameter int ENTRIES          = 8,
  parameter int DEVICE_ID_WIDTH  = 24,
  parameter int PROCESS_ID_WIDTH = 20,
  parameter int CONTENT_WIDTH    = 128,
  parameter int CNT_WIDTH        = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic                        flush_dv_i,
  input  logic [DEVICE_ID_WIDTH-1:0]  flush_did_i,
  input  logic                        flush_pv_i,
  input  logic [PROCESS_ID_WIDTH-1:0] flush_pid_i,
  input  logic                        up_i,
  input  logic [DEVICE_ID_WIDTH-1:0]  up_did_i,
  input  logic [PROCESS_ID_WIDTH-1:0] up_pid_i,
  input  logic [CONTENT_WIDTH-1:0]    up_content_i,
  input  logic                        lu_i,
  input  logic [DEVICE_ID_WIDTH-1:0]  lu_did_i,
  input  logic [PROCESS_ID_WIDTH-1:0] lu_pid_i,
  output logic                        lu_valid_o,
  output logic                        lu_hit_o,
  output logic [CONTENT_WIDTH-1:0]    lu_content_o,
  output logic [CNT_WIDTH-1:0]        hit_cnt_o,
  output logic [CNT_WIDTH-1:0]        miss_cnt_o
);
  localparam int IDXW = $clog2(ENTRIES);

  logic [ENTRIES-1:0]          valid_q, valid_d;
  logic [ENTRIES-2:0]          plru_q, plru_d;
  logic [DEVICE_ID_WIDTH-1:0]  did_q     [ENTRIES];
  logic [PROCESS_ID_WIDTH-1:0] pid_q     [ENTRIES];
  logic [CONTENT_WIDTH-1:0]    content_q [ENTRIES];
  logic                        lu_valid_q, lu_hit_q;
  logic [CONTENT_WIDTH-1:0]    lu_content_q;
  logic [CNT_WIDTH-1:0]        hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  logic [ENTRIES-1:0]          fl_inv_s;
  logic                        lu_hit_s, up_hit_s, free_s, up_we_s;
  logic [IDXW-1:0]             lu_idx_s, up_hit_idx_s, free_idx_s, up_idx_s;
  logic [CONTENT_WIDTH-1:0]    lu_content_s;

  // Each tree node on the path is pointed away from the touched entry (bit 0 = victim on the left).
  function automatic logic [ENTRIES-2:0] plru_touch(input logic [ENTRIES-2:0] t,
                                                    input logic [IDXW-1:0] idx);
    logic [IDXW-1:0] node;
    logic [IDXW-1:0] k;
    logic            b;
    node = '0;
    k    = idx;
    for (int l = 0; l < IDXW; l++) begin
      b       = k[IDXW-1];
      t[node] = ~b;
      node    = IDXW'(2 * int'(node) + 1 + int'(b));
      k       = k << 1;
    end
    return t;
  endfunction

  function automatic logic [IDXW-1:0] plru_victim(input logic [ENTRIES-2:0] t);
    logic [IDXW-1:0] node;
    logic [IDXW-1:0] v;
    node = '0;
    v    = '0;
    for (int l = 0; l < IDXW; l++) begin
      v    = (v << 1) | IDXW'(t[node]);
      node = IDXW'(2 * int'(node) + 1 + int'(t[node]));
    end
    return v;
  endfunction

  // Per-entry matching; descending scan leaves the lowest index as the winner.
  always_comb begin
    fl_inv_s     = '0;
    lu_hit_s     = 1'b0;
    lu_idx_s     = '0;
    lu_content_s = '0;
    up_hit_s     = 1'b0;
    up_hit_idx_s = '0;
    free_s       = 1'b0;
    free_idx_s   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      fl_inv_s[i] = flush_i && (!flush_dv_i || (did_q[i] == flush_did_i &&
                    (!flush_pv_i || pid_q[i] == flush_pid_i)));
      if (valid_q[i] && !fl_inv_s[i] && did_q[i] == lu_did_i && pid_q[i] == lu_pid_i) begin
        lu_hit_s     = 1'b1;
        lu_idx_s     = IDXW'(i);
        lu_content_s = content_q[i];
      end
      if (valid_q[i] && did_q[i] == up_did_i && pid_q[i] == up_pid_i) begin
        up_hit_s     = 1'b1;
        up_hit_idx_s = IDXW'(i);
      end
      if (!valid_q[i]) begin
        free_s     = 1'b1;
        free_idx_s = IDXW'(i);
      end
    end
  end

  // Next state: flush beats update; lookup touch precedes update touch.
  always_comb begin
    valid_d    = valid_q & ~fl_inv_s;
    plru_d     = plru_q;
    up_we_s    = up_i && !flush_i;
    up_idx_s   = up_hit_s ? up_hit_idx_s : (free_s ? free_idx_s : plru_victim(plru_q));
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (lu_i && lu_hit_s) begin
      plru_d = plru_touch(plru_d, lu_idx_s);
    end
    if (up_we_s) begin
      valid_d[up_idx_s] = 1'b1;
      plru_d            = plru_touch(plru_d, up_idx_s);
    end
    if (lu_i && lu_hit_s && hit_cnt_q != {CNT_WIDTH{1'b1}}) begin
      hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
    end
    if (lu_i && !lu_hit_s && miss_cnt_q != {CNT_WIDTH{1'b1}}) begin
      miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q      <= '0;
      plru_q       <= '0;
      lu_valid_q   <= 1'b0;
      lu_hit_q     <= 1'b0;
      lu_content_q <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      valid_q      <= valid_d;
      plru_q       <= plru_d;
      lu_valid_q   <= lu_i;
      lu_hit_q     <= lu_i && lu_hit_s;
      lu_content_q <= (lu_i && lu_hit_s) ? lu_content_s : '0;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // Tag and payload storage is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (up_we_s && !rst_i) begin
      did_q[up_idx_s]     <= up_did_i;
      pid_q[up_idx_s]     <= up_pid_i;
      content_q[up_idx_s] <= up_content_i;
    end
  end

  assign lu_valid_o   = lu_valid_q;
  assign lu_hit_o     = lu_hit_q;
  assign lu_content_o = lu_content_q;
  assign hit_cnt_o    = hit_cnt_q;
  assign miss_cnt_o   = miss_cnt_q;

endmodule

// File: tb/tb_iommu_pdtc.sv
// Directed bench for iommu_pdtc with 4 entries and 4-bit counters.
module tb_iommu_pdtc;
  localparam int E  = 4;
  localparam int DW = 24;
  localparam int PW = 20;
  localparam int CW = 128;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst_i, flush_i, flush_dv_i, flush_pv_i, up_i, lu_i;
  logic [DW-1:0] flush_did_i, up_did_i, lu_did_i;
  logic [PW-1:0] flush_pid_i, up_pid_i, lu_pid_i;
  logic [CW-1:0] up_content_i, lu_content_o;
  logic          lu_valid_o, lu_hit_o;
  logic [NW-1:0] hit_cnt_o, miss_cnt_o;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [NW-1:0] hit_m, miss_m;

  iommu_pdtc #(.ENTRIES(E), .DEVICE_ID_WIDTH(DW), .PROCESS_ID_WIDTH(PW),
               .CONTENT_WIDTH(CW), .CNT_WIDTH(NW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .flush_i(flush_i), .flush_dv_i(flush_dv_i), .flush_did_i(flush_did_i),
    .flush_pv_i(flush_pv_i), .flush_pid_i(flush_pid_i),
    .up_i(up_i), .up_did_i(up_did_i), .up_pid_i(up_pid_i), .up_content_i(up_content_i),
    .lu_i(lu_i), .lu_did_i(lu_did_i), .lu_pid_i(lu_pid_i),
    .lu_valid_o(lu_valid_o), .lu_hit_o(lu_hit_o), .lu_content_o(lu_content_o),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    lu_i    = 1'b0;
    up_i    = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic fill(input logic [DW-1:0] d, input logic [PW-1:0] p, input logic [CW-1:0] c);
    up_i = 1'b1; up_did_i = d; up_pid_i = p; up_content_i = c;
    tick();
  endtask

  task automatic flush(input logic dv, input logic pv, input logic [DW-1:0] d, input logic [PW-1:0] p);
    flush_i = 1'b1; flush_dv_i = dv; flush_pv_i = pv; flush_did_i = d; flush_pid_i = p;
    tick();
  endtask

  // Issues a lookup (together with any flush/update already set up) and checks the response.
  task automatic lookup(input logic [DW-1:0] d, input logic [PW-1:0] p, input logic eh,
                        input logic [CW-1:0] ec);
    string t;
    lu_i = 1'b1; lu_did_i = d; lu_pid_i = p;
    tick();
    if (eh) begin
      if (hit_m != 4'hF) hit_m = hit_m + 4'd1;
    end else begin
      if (miss_m != 4'hF) miss_m = miss_m + 4'd1;
    end
    t = $sformatf("(%0h,%0h)", d, p);
    check_eq({"lu_valid", t}, CW'(lu_valid_o), CW'(1'b1));
    check_eq({"lu_hit", t}, CW'(lu_hit_o), CW'(eh));
    check_eq({"lu_content", t}, lu_content_o, eh ? ec : '0);
    check_eq({"hit_cnt", t}, CW'(hit_cnt_o), CW'(hit_m));
    check_eq({"miss_cnt", t}, CW'(miss_cnt_o), CW'(miss_m));
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; flush_dv_i = 1'b0; flush_pv_i = 1'b0; up_i = 1'b0;
    flush_did_i = '0; flush_pid_i = '0; up_did_i = '0; up_pid_i = '0; up_content_i = '0;
    lu_i = 1'b1; lu_did_i = 24'd5; lu_pid_i = 20'd3;
    hit_m = 4'd0; miss_m = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_lu_valid", CW'(lu_valid_o), CW'(1'b0));
    check_eq("rst_lu_hit", CW'(lu_hit_o), CW'(1'b0));
    check_eq("rst_content", lu_content_o, '0);
    check_eq("rst_hit_cnt", CW'(hit_cnt_o), CW'(4'd0));
    check_eq("rst_miss_cnt", CW'(miss_cnt_o), CW'(4'd0));
    rst_i = 1'b0; lu_i = 1'b0;
    tick();

    // Cold miss, fill, in-place overwrite.
    lookup(24'd5, 20'd3, 1'b0, '0);
    fill(24'd5, 20'd3, 128'hA5);
    lookup(24'd5, 20'd3, 1'b1, 128'hA5);
    fill(24'd5, 20'd3, 128'h5A);
    lookup(24'd5, 20'd3, 1'b1, 128'h5A);
    fill(24'd6, 20'd0, 128'h60);
    fill(24'd6, 20'd1, 128'h61);
    fill(24'd6, 20'd2, 128'h62);
    lookup(24'd5, 20'd3, 1'b1, 128'h5A);
    lookup(24'd6, 20'd0, 1'b1, 128'h60);
    lookup(24'd6, 20'd1, 1'b1, 128'h61);
    lookup(24'd6, 20'd2, 1'b1, 128'h62);
    tick();
    check_eq("lu_valid_idle", CW'(lu_valid_o), CW'(1'b0));

    // Replacement: fills leave the tree pointing at entry 0 after hits on 1,2,3.
    flush(1'b0, 1'b0, '0, '0);
    lookup(24'd5, 20'd3, 1'b0, '0);
    for (int k = 0; k < 4; k++) fill(24'd1, PW'(k), CW'(16 + k));
    for (int k = 1; k < 4; k++) lookup(24'd1, PW'(k), 1'b1, CW'(16 + k));
    fill(24'd1, 20'd9, 128'h99);
    lookup(24'd1, 20'd0, 1'b0, '0);
    lookup(24'd1, 20'd9, 1'b1, 128'h99);
    lookup(24'd1, 20'd3, 1'b1, 128'h13);

    // Three flush modes.
    flush(1'b0, 1'b1, 24'd1, 20'd9);
    fill(24'd1, 20'd1, 128'h11);
    fill(24'd1, 20'd2, 128'h12);
    fill(24'd2, 20'd1, 128'h21);
    flush(1'b1, 1'b1, 24'd1, 20'd2);
    lookup(24'd1, 20'd1, 1'b1, 128'h11);
    lookup(24'd1, 20'd2, 1'b0, '0);
    lookup(24'd2, 20'd1, 1'b1, 128'h21);
    flush(1'b1, 1'b0, 24'd1, 20'd7);
    lookup(24'd1, 20'd1, 1'b0, '0);
    lookup(24'd2, 20'd1, 1'b1, 128'h21);
    flush(1'b0, 1'b0, '0, '0);
    lookup(24'd2, 20'd1, 1'b0, '0);

    // Same-cycle collisions.
    fill(24'd7, 20'd7, 128'h77);
    flush_i = 1'b1; flush_dv_i = 1'b1; flush_pv_i = 1'b1; flush_did_i = 24'd8; flush_pid_i = 20'd8;
    lookup(24'd7, 20'd7, 1'b1, 128'h77);
    flush_i = 1'b1; flush_dv_i = 1'b1; flush_pv_i = 1'b1; flush_did_i = 24'd7; flush_pid_i = 20'd7;
    lookup(24'd7, 20'd7, 1'b0, '0);
    lookup(24'd7, 20'd7, 1'b0, '0);
    flush_i = 1'b1; flush_dv_i = 1'b0;
    fill(24'd3, 20'd3, 128'h33);
    lookup(24'd3, 20'd3, 1'b0, '0);
    up_i = 1'b1; up_did_i = 24'd4; up_pid_i = 20'd4; up_content_i = 128'h44;
    lookup(24'd4, 20'd4, 1'b0, '0);
    lookup(24'd4, 20'd4, 1'b1, 128'h44);

    // Back-to-back misses push the miss counter into saturation.
    for (int k = 0; k < 20; k++) lookup(24'hABC, PW'(k), 1'b0, '0);
    check_eq("miss_sat", CW'(miss_cnt_o), CW'(4'hF));
    tick();
    check_eq("lu_valid_drop", CW'(lu_valid_o), CW'(1'b0));

    // Reset mid-stream clears counters and suppresses the response.
    lu_i = 1'b1; lu_did_i = 24'd4; lu_pid_i = 20'd4;
    rst_i = 1'b1;
    tick();
    check_eq("mid_rst_valid", CW'(lu_valid_o), CW'(1'b0));
    check_eq("mid_rst_hit_cnt", CW'(hit_cnt_o), CW'(4'd0));
    check_eq("mid_rst_miss_cnt", CW'(miss_cnt_o), CW'(4'd0));
    rst_i = 1'b0;
    hit_m = 4'd0; miss_m = 4'd0;
    lookup(24'd4, 20'd4, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
